// File: rtl/ltssm_os_decoder_if.sv
// Receive symbol stream of one lane: 4 symbols per beat with per-byte K flags.
// The decoder never back-pressures; tready only reports "out of reset".
interface ltssm_os_decoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/ltssm_os_decoder.sv
// Per-lane TS1/TS2 ordered-set decoder for LTSSM Polling/Configuration.
// Word-aligned input (COM in byte0); a TS spans 4 beats and is reported 1 clk after its last beat.
module ltssm_os_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 4,
  parameter int IDLE_MIN   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  ltssm_os_decoder_if.slave s_axis,
  output logic              ts1_valid_o,
  output logic              ts2_valid_o,
  output logic              idle_valid_o,
  output logic [7:0]        link_num_o,
  output logic [7:0]        lane_num_o,
  output logic              link_pad_o,
  output logic              lane_pad_o,
  output logic [7:0]        n_fts_o,
  output logic [7:0]        rate_id_o,
  output logic [7:0]        training_ctrl_o,
  output logic [3:0]        consec_cnt_o,
  output logic              error_o
);

  localparam int NSYM = DATA_WIDTH / 8;
  localparam int CW   = $clog2(IDLE_MIN + 1);

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] ID_TS1 = 8'h4A;
  localparam logic [7:0] ID_TS2 = 8'h45;

  typedef enum logic [1:0] {S_SEARCH, S_B1, S_B2, S_B3} state_t;
  typedef enum logic [1:0] {KIND_NONE, KIND_TS1, KIND_TS2} kind_t;

  state_t          r_state;
  kind_t           r_last_kind;
  logic            r_ready;
  logic [CW-1:0]   r_idle_cnt;
  // Fields staged while the OS is in flight, published only on completion
  logic [7:0]      r_s_link, r_s_lane, r_s_nfts, r_s_rate, r_s_tctrl, r_s_id;
  logic            r_s_link_pad, r_s_lane_pad;

  logic [7:0]            w_sym [NSYM];
  logic [USER_WIDTH-1:0] w_k;
  logic w_com, w_skp1, w_skp, w_zero_beat, w_b0_ok, w_b1_ok, w_b23_ok, w_same;
  kind_t w_kind;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    w_k = s_axis.tuser;
    for (int i = 0; i < NSYM; i++) w_sym[i] = s_axis.tdata[8*i +: 8];
    w_com       = w_k[0] && (w_sym[0] == K_COM);
    w_skp1      = w_k[1] && (w_sym[1] == K_SKP);
    w_skp       = w_com && (&w_k[3:1]) && (w_sym[1] == K_SKP) &&
                  (w_sym[2] == K_SKP) && (w_sym[3] == K_SKP);
    w_zero_beat = (w_k == '0) && (s_axis.tdata == '0);
    w_b0_ok     = (!w_k[1] || (w_sym[1] == K_PAD)) &&
                  (!w_k[2] || (w_sym[2] == K_PAD)) && !w_k[3];
    w_b1_ok     = (w_k == '0) && ((w_sym[2] == ID_TS1) || (w_sym[2] == ID_TS2)) &&
                  (w_sym[3] == w_sym[2]);
    w_b23_ok    = (w_k == '0);
    for (int i = 0; i < NSYM; i++)
      if (w_sym[i] != r_s_id) w_b23_ok = 1'b0;
    w_kind = (r_s_id == ID_TS2) ? KIND_TS2 : KIND_TS1;
    // N_FTS deliberately excluded from the identity test
    w_same = (w_kind == r_last_kind) && (r_s_link == link_num_o) && (r_s_lane == lane_num_o) &&
             (r_s_link_pad == link_pad_o) && (r_s_lane_pad == lane_pad_o) &&
             (r_s_rate == rate_id_o) && (r_s_tctrl == training_ctrl_o);
  end

  assign s_axis.tready = r_ready;
  assign idle_valid_o  = (r_idle_cnt >= CW'(IDLE_MIN));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= S_SEARCH;
      r_last_kind     <= KIND_NONE;
      r_ready         <= 1'b0;
      r_idle_cnt      <= '0;
      r_s_link        <= '0;
      r_s_lane        <= '0;
      r_s_nfts        <= '0;
      r_s_rate        <= '0;
      r_s_tctrl       <= '0;
      r_s_id          <= '0;
      r_s_link_pad    <= 1'b0;
      r_s_lane_pad    <= 1'b0;
      ts1_valid_o     <= 1'b0;
      ts2_valid_o     <= 1'b0;
      link_num_o      <= '0;
      lane_num_o      <= '0;
      link_pad_o      <= 1'b0;
      lane_pad_o      <= 1'b0;
      n_fts_o         <= '0;
      rate_id_o       <= '0;
      training_ctrl_o <= '0;
      consec_cnt_o    <= '0;
      error_o         <= 1'b0;
    end else begin
      r_ready     <= 1'b1;
      ts1_valid_o <= 1'b0;
      ts2_valid_o <= 1'b0;
      error_o     <= 1'b0;
      if (!en_i) begin
        r_state      <= S_SEARCH;
        r_idle_cnt   <= '0;
        consec_cnt_o <= '0;
      end else if (s_axis.tvalid) begin
        if (!(r_state == S_SEARCH && (w_zero_beat || w_skp))) r_idle_cnt <= '0;
        unique case (r_state)
          S_SEARCH: begin
            if (w_zero_beat) begin
              if (r_idle_cnt < CW'(IDLE_MIN)) r_idle_cnt <= r_idle_cnt + CW'(4);
            end else if (w_com && !w_skp1) begin
              if (w_b0_ok) begin
                r_s_link     <= w_sym[1];
                r_s_lane     <= w_sym[2];
                r_s_nfts     <= w_sym[3];
                r_s_link_pad <= w_k[1];
                r_s_lane_pad <= w_k[2];
                r_state      <= S_B1;
              end else begin
                error_o      <= 1'b1;
                consec_cnt_o <= '0;
              end
            end
          end
          S_B1: begin
            if (w_b1_ok) begin
              r_s_rate  <= w_sym[0];
              r_s_tctrl <= w_sym[1];
              r_s_id    <= w_sym[2];
              r_state   <= S_B2;
            end else begin
              error_o      <= 1'b1;
              consec_cnt_o <= '0;
              r_state      <= S_SEARCH;
            end
          end
          S_B2: begin
            if (w_b23_ok) begin
              r_state <= S_B3;
            end else begin
              error_o      <= 1'b1;
              consec_cnt_o <= '0;
              r_state      <= S_SEARCH;
            end
          end
          S_B3: begin
            r_state <= S_SEARCH;
            if (w_b23_ok) begin
              ts1_valid_o     <= (w_kind == KIND_TS1);
              ts2_valid_o     <= (w_kind == KIND_TS2);
              r_last_kind     <= w_kind;
              link_num_o      <= r_s_link;
              lane_num_o      <= r_s_lane;
              link_pad_o      <= r_s_link_pad;
              lane_pad_o      <= r_s_lane_pad;
              n_fts_o         <= r_s_nfts;
              rate_id_o       <= r_s_rate;
              training_ctrl_o <= r_s_tctrl;
              if (!w_same)                   consec_cnt_o <= 4'd1;
              else if (consec_cnt_o != 4'hF) consec_cnt_o <= consec_cnt_o + 4'd1;
            end else begin
              error_o      <= 1'b1;
              consec_cnt_o <= '0;
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltssm_os_decoder.sv
// Directed bench for ltssm_os_decoder: TS1/TS2 decode, consecutive counting, errors, SKP, idle, reset.
module tb_ltssm_os_decoder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic en_i  = 1'b1;

  logic       ts1_valid_o, ts2_valid_o, idle_valid_o, link_pad_o, lane_pad_o, error_o;
  logic [7:0] link_num_o, lane_num_o, n_fts_o, rate_id_o, training_ctrl_o;
  logic [3:0] consec_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  ltssm_os_decoder_if #(.DATA_WIDTH(32), .USER_WIDTH(4)) s_axis ();

  ltssm_os_decoder #(.DATA_WIDTH(32), .USER_WIDTH(4), .IDLE_MIN(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .s_axis          (s_axis),
    .ts1_valid_o     (ts1_valid_o),
    .ts2_valid_o     (ts2_valid_o),
    .idle_valid_o    (idle_valid_o),
    .link_num_o      (link_num_o),
    .lane_num_o      (lane_num_o),
    .link_pad_o      (link_pad_o),
    .lane_pad_o      (lane_pad_o),
    .n_fts_o         (n_fts_o),
    .rate_id_o       (rate_id_o),
    .training_ctrl_o (training_ctrl_o),
    .consec_cnt_o    (consec_cnt_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one beat at the falling edge; return 1 ns after the accepting rising edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k);
    @(negedge clk_i);
    s_axis.tdata  = d;
    s_axis.tuser  = k;
    s_axis.tvalid = 1'b1;
    @(posedge clk_i);
    #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic idle_clk();
    @(posedge clk_i);
    #1;
  endtask

  // Build the 16-symbol TS image; one data symbol may be overridden for error injection.
  task automatic build_ts(input logic ts2, input logic [7:0] link, input logic [7:0] lane,
                          input logic link_pad, input logic lane_pad, input logic [7:0] nfts,
                          input logic [7:0] rate, input logic [7:0] tctrl,
                          input int bad_idx, input logic [7:0] bad_val,
                          output logic [31:0] beats [4], output logic [3:0] ks [4]);
    logic [7:0] sym [16];
    logic [7:0] id;
    id = ts2 ? 8'h45 : 8'h4A;
    sym[0] = 8'hBC;
    sym[1] = link_pad ? 8'hF7 : link;
    sym[2] = lane_pad ? 8'hF7 : lane;
    sym[3] = nfts;
    sym[4] = rate;
    sym[5] = tctrl;
    for (int i = 6; i < 16; i++) sym[i] = id;
    if (bad_idx >= 0) sym[bad_idx] = bad_val;
    for (int b = 0; b < 4; b++) begin
      beats[b] = {sym[4*b+3], sym[4*b+2], sym[4*b+1], sym[4*b]};
      ks[b]    = 4'b0000;
    end
    ks[0] = {1'b0, lane_pad, link_pad, 1'b1};
  endtask

  task automatic send_ts(input logic ts2, input logic [7:0] link, input logic [7:0] lane,
                         input logic link_pad, input logic lane_pad, input logic [7:0] nfts,
                         input logic [7:0] rate, input logic [7:0] tctrl,
                         input int bad_idx, input logic [7:0] bad_val);
    logic [31:0] beats [4];
    logic [3:0]  ks [4];
    build_ts(ts2, link, lane, link_pad, lane_pad, nfts, rate, tctrl, bad_idx, bad_val, beats, ks);
    for (int b = 0; b < 4; b++) send_beat(beats[b], ks[b]);
  endtask

  logic [31:0] t_beats [4];
  logic [3:0]  t_ks [4];
  int          pulses;

  initial begin
    s_axis.tdata  = '0;
    s_axis.tuser  = '0;
    s_axis.tvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tready", s_axis.tready, 0);
    check("rst_ts1", ts1_valid_o, 0);
    check("rst_consec", consec_cnt_o, 0);
    check("rst_link", link_num_o, 0);
    check("rst_idle", idle_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_clk();
    check("tready_up", s_axis.tready, 1);

    // 1: single TS1, pulse exactly one clock after the final beat
    build_ts(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00, -1, 8'h00, t_beats, t_ks);
    for (int b = 0; b < 3; b++) send_beat(t_beats[b], t_ks[b]);
    check("t1_no_early_pulse", ts1_valid_o, 0);
    send_beat(t_beats[3], t_ks[3]);
    check("t1_ts1", ts1_valid_o, 1);
    check("t1_ts2", ts2_valid_o, 0);
    check("t1_link", link_num_o, 8'h01);
    check("t1_lane", lane_num_o, 8'h02);
    check("t1_nfts", n_fts_o, 8'h10);
    check("t1_rate", rate_id_o, 8'h02);
    check("t1_tctrl", training_ctrl_o, 8'h00);
    check("t1_pads", {link_pad_o, lane_pad_o}, 2'b00);
    check("t1_consec", consec_cnt_o, 1);
    idle_clk();
    check("t1_pulse_1clk", ts1_valid_o, 0);

    // 2: 16 identical TS2 with lane=PAD; N_FTS varies and must not break identity
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      send_ts(1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 8'h20 + 8'(i), 8'h02, 8'h00, -1, 8'h00);
      if (ts2_valid_o) pulses++;
      check($sformatf("t2_consec_%0d", i), consec_cnt_o, (i < 15) ? i + 1 : 15);
    end
    check("t2_pulses", pulses, 16);
    check("t2_lane_pad", lane_pad_o, 1);
    check("t2_link_pad", link_pad_o, 0);
    check("t2_nfts_last", n_fts_o, 8'h2F);

    // 3: TS1 with byte9 = 0x45 -> error at B2, fields held, then a good TS1 restarts count
    build_ts(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00, 9, 8'h45, t_beats, t_ks);
    for (int b = 0; b < 3; b++) send_beat(t_beats[b], t_ks[b]);
    check("t3_error", error_o, 1);
    check("t3_consec0", consec_cnt_o, 0);
    send_beat(t_beats[3], t_ks[3]);
    check("t3_no_ts1", ts1_valid_o, 0);
    check("t3_error_1clk", error_o, 0);
    check("t3_link_held", link_num_o, 8'h05);
    send_ts(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00, -1, 8'h00);
    check("t3_good_ts1", ts1_valid_o, 1);
    check("t3_good_consec", consec_cnt_o, 1);

    // 4: TS1, SKP, identical TS1 -> consec 2; then SKP inside B2 -> error
    send_ts(1'b0, 8'h03, 8'h02, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00, -1, 8'h00);
    check("t4_first", consec_cnt_o, 1);
    send_beat(32'h1C1C1CBC, 4'b1111);
    check("t4_skp_no_err", error_o, 0);
    send_ts(1'b0, 8'h03, 8'h02, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00, -1, 8'h00);
    check("t4_second_ts1", ts1_valid_o, 1);
    check("t4_consec2", consec_cnt_o, 2);
    build_ts(1'b0, 8'h03, 8'h02, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00, -1, 8'h00, t_beats, t_ks);
    send_beat(t_beats[0], t_ks[0]);
    send_beat(t_beats[1], t_ks[1]);
    send_beat(32'h1C1C1CBC, 4'b1111);
    check("t4_skp_mid_err", error_o, 1);
    check("t4_skp_mid_consec", consec_cnt_o, 0);

    // 5: idle detection; SKP leaves count intact, a COM beat clears it next clk
    send_beat(32'h0, 4'b0000);
    check("t5_idle_after1", idle_valid_o, 0);
    send_beat(32'h0, 4'b0000);
    check("t5_idle_after2", idle_valid_o, 1);
    send_beat(32'h1C1C1CBC, 4'b1111);
    check("t5_idle_skp", idle_valid_o, 1);
    send_beat(32'h0, 4'b0000);
    check("t5_idle_sat", idle_valid_o, 1);
    build_ts(1'b0, 8'h03, 8'h02, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00, -1, 8'h00, t_beats, t_ks);
    send_beat(t_beats[0], t_ks[0]);
    check("t5_idle_cleared", idle_valid_o, 0);
    for (int b = 1; b < 4; b++) send_beat(t_beats[b], t_ks[b]);
    check("t5_ts1", ts1_valid_o, 1);
    check("t5_consec_after_err", consec_cnt_o, 1);

    // en_i low: counters cleared, a full TS is ignored
    @(negedge clk_i);
    en_i = 1'b0;
    idle_clk();
    check("en_consec0", consec_cnt_o, 0);
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      send_beat(t_beats[b], t_ks[b]);
      if (ts1_valid_o) pulses++;
    end
    check("en_no_pulse", pulses, 0);
    check("en_link_held", link_num_o, 8'h03);
    @(negedge clk_i);
    en_i = 1'b1;

    // 6: async reset during B2, then a full TS2
    build_ts(1'b1, 8'h07, 8'h01, 1'b0, 1'b0, 8'h08, 8'h02, 8'h01, -1, 8'h00, t_beats, t_ks);
    send_beat(t_beats[0], t_ks[0]);
    send_beat(t_beats[1], t_ks[1]);
    @(negedge clk_i);
    s_axis.tdata  = t_beats[2];
    s_axis.tuser  = t_ks[2];
    s_axis.tvalid = 1'b1;
    rst_i = 1'b1;
    #1;
    check("t6_rst_tready", s_axis.tready, 0);
    check("t6_rst_link", link_num_o, 0);
    pulses = 0;
    repeat (2) begin
      idle_clk();
      if (ts2_valid_o || ts1_valid_o || error_o) pulses++;
    end
    s_axis.tvalid = 1'b0;
    check("t6_no_pulse_in_rst", pulses, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_clk();
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      send_beat(t_beats[b], t_ks[b]);
      if (ts2_valid_o) pulses++;
    end
    check("t6_one_pulse", pulses, 1);
    check("t6_ts2_now", ts2_valid_o, 1);
    check("t6_consec", consec_cnt_o, 1);
    check("t6_link", link_num_o, 8'h07);
    check("t6_tctrl", training_ctrl_o, 8'h01);
    idle_clk();
    check("t6_pulse_1clk", ts2_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
